// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped countdown timer raising IRQ on expiry
// Four-state engine (IDLE/LOAD/CNT/INT); one-shot level IRQ or auto-reload one-cycle pulse.
module timer_irq (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr_bits;

    assign wr_ctrl          = WE && (Addr[3:2] == 2'd0);
    assign wr_preset        = WE && (Addr[3:2] == 2'd1);
    assign unused_addr_bits = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Bus clear is applied before the engine so an expiry in the same cycle still sets the flag.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[2:1] == 2'd1) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software CTRL write overrides the hardware EN clear on expiry.
        if (wr_ctrl) begin
            ctrl_d = Din[3:0];
        end
        if (wr_preset) begin
            preset_d = Din;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[3];

endmodule
